// File: rtl/line_word_select_if.sv
// rtl/line_word_select_if.sv - request/response bundle for the line word selector
interface line_word_select_if #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 4
);
    localparam int SEL_W = $clog2(WORDS);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    logic                        in_valid;
    logic                        in_ready;
    logic [WORDS*DATA_WIDTH-1:0] in_line;
    logic [SEL_W-1:0]            in_sel;
    logic [OFF_W-1:0]            in_off;
    logic [1:0]                  in_size;
    logic                        in_signed;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out_data;
    logic                        out_err;

    modport slave (
        input  in_valid, in_line, in_sel, in_off, in_size, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_line, in_sel, in_off, in_size, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/line_word_select.sv
// rtl/line_word_select.sv - cache line word/byte/half extract with skid-buffered output
module line_word_select #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 4
) (
    input  logic               clk,
    input  logic               rst,
    line_word_select_if.slave  bus
);
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_err;

    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_err_q, m_err_d;
    logic                  s_valid_q, s_valid_d;
    logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
    logic                  s_err_q, s_err_d;

    logic accept;
    logic drain;

    // Extraction: shift the selected byte offset down to bit 0, then narrow and extend.
    always_comb begin
        word     = bus.in_line[bus.in_sel*DATA_WIDTH +: DATA_WIDTH];
        shifted  = word >> {bus.in_off, 3'b000};
        res_err  = 1'b0;
        res_data = '0;
        case (bus.in_size)
            2'b00: res_data = {{(DATA_WIDTH-8){bus.in_signed & shifted[7]}}, shifted[7:0]};
            2'b01: begin
                res_err  = bus.in_off[0];
                res_data = {{(DATA_WIDTH-16){bus.in_signed & shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                res_err  = (bus.in_off != '0);
                res_data = shifted;
            end
            default: res_err = 1'b1;
        endcase
        if (res_err) begin
            res_data = '0;
        end
    end

    // in_ready depends only on the skid slot and reset, never on out_ready.
    assign bus.in_ready  = !s_valid_q && !rst;
    assign bus.out_valid = m_valid_q;
    assign bus.out_data  = m_data_q;
    assign bus.out_err   = m_err_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = m_valid_q && bus.out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_err_d   = m_err_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_err_d   = s_err_q;
        if (!m_valid_q || drain) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                m_err_d   = s_err_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_data_d  = res_data;
                m_err_d   = res_err;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = res_data;
            s_err_d   = res_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_err_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_err_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_err_q   <= m_err_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_err_q   <= s_err_d;
        end
    end
endmodule

// File: tb/tb_line_word_select.sv
// tb/tb_line_word_select.sv - directed table, skid/reset sequences and 64-bit scoreboard sweep
module tb_line_word_select;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_word_select_if #(.DATA_WIDTH(32), .WORDS(4)) b32 ();
    line_word_select_if #(.DATA_WIDTH(64), .WORDS(8)) b64 ();

    line_word_select #(.DATA_WIDTH(32), .WORDS(4)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    line_word_select #(.DATA_WIDTH(64), .WORDS(8)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] line;
        logic [1:0]   sel;
        logic [1:0]   off;
        logic [1:0]   size;
        logic         sgn;
        logic [31:0]  exp_data;
        logic         exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    vec_t vecs[14];

    function automatic exp_t model64(input logic [511:0] line, input int sel, input int off,
                                     input int size, input logic sgn);
        exp_t        r;
        logic [63:0] w;
        logic [7:0]  by[8];
        logic [15:0] h;
        w = line[sel*64 +: 64];
        for (int i = 0; i < 8; i++) by[i] = w[i*8 +: 8];
        h = {by[(off+1)%8], by[off]};
        r.err = (size == 3) || (size == 1 && (off % 2) == 1) || (size == 2 && off != 0);
        case (size)
            0:       r.data = sgn ? 64'($signed(by[off])) : 64'(by[off]);
            1:       r.data = sgn ? 64'($signed(h)) : 64'(h);
            default: r.data = w;
        endcase
        if (r.err) r.data = '0;
        return r;
    endfunction

    task automatic drive32(input vec_t v);
        b32.in_valid  = 1'b1;
        b32.in_line   = v.line;
        b32.in_sel    = v.sel;
        b32.in_off    = v.off;
        b32.in_size   = v.size;
        b32.in_signed = v.sgn;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] l1, l2;
    exp_t         q[$];
    exp_t         e;
    logic [511:0] rline;
    int           acc_n, cycles, rsel, roff, rsize;
    logic         rsgn, prev_hold, prev_err;
    logic [63:0]  prev_data;

    initial begin
        b32.in_valid = 0; b32.in_line = '0; b32.in_sel = '0; b32.in_off = '0;
        b32.in_size = '0; b32.in_signed = 0; b32.out_ready = 1;
        b64.in_valid = 0; b64.in_line = '0; b64.in_sel = '0; b64.in_off = '0;
        b64.in_size = '0; b64.in_signed = 0; b64.out_ready = 1;

        l1 = {32'd300, 32'd200, 32'd100, 32'd0};
        l2 = {32'd300, 32'h80F1_7F85, 32'd100, 32'd0};
        vecs[0]  = '{l1, 2'd0, 2'd0, 2'b10, 1'b0, 32'd0,          1'b0};
        vecs[1]  = '{l1, 2'd1, 2'd0, 2'b10, 1'b0, 32'd100,        1'b0};
        vecs[2]  = '{l1, 2'd2, 2'd0, 2'b10, 1'b0, 32'd200,        1'b0};
        vecs[3]  = '{l1, 2'd3, 2'd0, 2'b10, 1'b0, 32'd300,        1'b0};
        vecs[4]  = '{l2, 2'd2, 2'd0, 2'b00, 1'b1, 32'hFFFF_FF85,  1'b0};
        vecs[5]  = '{l2, 2'd2, 2'd0, 2'b00, 1'b0, 32'h0000_0085,  1'b0};
        vecs[6]  = '{l2, 2'd2, 2'd1, 2'b00, 1'b1, 32'h0000_007F,  1'b0};
        vecs[7]  = '{l2, 2'd2, 2'd3, 2'b00, 1'b1, 32'hFFFF_FF80,  1'b0};
        vecs[8]  = '{l2, 2'd2, 2'd2, 2'b01, 1'b1, 32'hFFFF_80F1,  1'b0};
        vecs[9]  = '{l2, 2'd2, 2'd2, 2'b01, 1'b0, 32'h0000_80F1,  1'b0};
        vecs[10] = '{l2, 2'd2, 2'd0, 2'b01, 1'b0, 32'h0000_7F85,  1'b0};
        vecs[11] = '{l2, 2'd2, 2'd1, 2'b01, 1'b1, 32'h0,          1'b1};
        vecs[12] = '{l2, 2'd2, 2'd3, 2'b10, 1'b0, 32'h0,          1'b1};
        vecs[13] = '{l2, 2'd2, 2'd0, 2'b11, 1'b0, 32'h0,          1'b1};

        // Reset state
        repeat (2) step();
        chk("rst_out_valid", 65'(b32.out_valid), 65'(0));
        chk("rst_out_data",  65'(b32.out_data),  65'(0));
        chk("rst_out_err",   65'(b32.out_err),   65'(0));
        chk("rst_in_ready",  65'(b32.in_ready),  65'(0));
        rst = 0;
        step();
        chk("post_rst_in_ready", 65'(b32.in_ready), 65'(1));
        chk("post_rst_out_valid", 65'(b32.out_valid), 65'(0));

        // Table: one request per cycle, result one cycle after accept
        for (int i = 0; i < 14; i++) begin
            drive32(vecs[i]);
            chk($sformatf("vec%0d_in_ready", i), 65'(b32.in_ready), 65'(1));
            step();
            chk($sformatf("vec%0d_valid", i), 65'(b32.out_valid), 65'(1));
            chk($sformatf("vec%0d_data", i),  65'(b32.out_data),  65'(vecs[i].exp_data));
            chk($sformatf("vec%0d_err", i),   65'(b32.out_err),   65'(vecs[i].exp_err));
        end
        b32.in_valid = 0;
        step();
        chk("table_drain_valid", 65'(b32.out_valid), 65'(0));

        // Backpressure: A then B fill M and S, C is held
        b32.out_ready = 0;
        drive32(vecs[1]);
        step();
        chk("bp_a_in_ready", 65'(b32.in_ready), 65'(1));
        chk("bp_a_data", 65'(b32.out_data), 65'(100));
        drive32(vecs[2]);
        step();
        chk("bp_b_in_ready", 65'(b32.in_ready), 65'(0));
        chk("bp_b_data", 65'(b32.out_data), 65'(100));
        drive32(vecs[3]);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp_hold_valid",    65'(b32.out_valid), 65'(1));
            chk("bp_hold_data",     65'(b32.out_data),  65'(100));
            chk("bp_hold_in_ready", 65'(b32.in_ready),  65'(0));
        end
        b32.out_ready = 1;
        step();
        chk("bp_drain_b_data", 65'(b32.out_data), 65'(200));
        chk("bp_drain_in_ready", 65'(b32.in_ready), 65'(1));
        step();
        chk("bp_drain_c_valid", 65'(b32.out_valid), 65'(1));
        chk("bp_drain_c_data", 65'(b32.out_data), 65'(300));
        b32.in_valid = 0;
        step();
        chk("bp_empty_valid", 65'(b32.out_valid), 65'(0));

        // Reset with M and S both full
        b32.out_ready = 0;
        drive32(vecs[1]);
        step();
        drive32(vecs[2]);
        step();
        chk("mr_full_data", 65'(b32.out_data), 65'(100));
        chk("mr_full_in_ready", 65'(b32.in_ready), 65'(0));
        b32.in_valid = 0;
        rst = 1;
        step();
        chk("mr_out_valid", 65'(b32.out_valid), 65'(0));
        chk("mr_out_err",   65'(b32.out_err),   65'(0));
        chk("mr_out_data",  65'(b32.out_data),  65'(0));
        chk("mr_in_ready",  65'(b32.in_ready),  65'(0));
        rst = 0;
        b32.out_ready = 1;
        step();
        chk("mr_after_in_ready", 65'(b32.in_ready), 65'(1));
        for (int i = 0; i < 3; i++) begin
            chk("mr_no_stale_valid", 65'(b32.out_valid), 65'(0));
            step();
        end

        // 64-bit, 8-word sweep against the scoreboard model
        acc_n = 0;
        cycles = 0;
        prev_hold = 0;
        prev_data = '0;
        prev_err = 0;
        while ((acc_n < 10000 || q.size() > 0) && cycles < 80000) begin
            step();
            for (int k = 0; k < 16; k++) rline[k*32 +: 32] = $urandom;
            rsel  = $urandom_range(0, 7);
            roff  = $urandom_range(0, 7);
            rsize = $urandom_range(0, 3);
            rsgn  = 1'($urandom_range(0, 1));
            b64.in_valid  = (acc_n < 10000) && ($urandom_range(0, 3) != 0);
            b64.in_line   = rline;
            b64.in_sel    = 3'(rsel);
            b64.in_off    = 3'(roff);
            b64.in_size   = 2'(rsize);
            b64.in_signed = rsgn;
            b64.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_hold)
                chk("rand_stable", {b64.out_valid, b64.out_err, b64.out_data},
                    {1'b1, prev_err, prev_data});
            if (b64.out_valid && b64.out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_out", 65'(1), 65'(0));
                end else begin
                    e = q.pop_front();
                    chk("rand_out", {b64.out_err, b64.out_data}, {e.err, e.data});
                end
            end
            prev_hold = b64.out_valid && !b64.out_ready;
            prev_data = b64.out_data;
            prev_err  = b64.out_err;
            if (b64.in_valid && b64.in_ready) begin
                q.push_back(model64(rline, rsel, roff, rsize, rsgn));
                acc_n++;
            end
            cycles++;
        end
        chk("rand_accepted", 65'(acc_n), 65'(10000));
        chk("rand_queue_empty", 65'(q.size()), 65'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
